// File: rtl/id_stage_if.sv
// Handshake and writeback bundle for the RV32I decode stage.
// master = upstream/writeback/ALU side, slave = id_stage.
interface id_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_op;
   logic [31:0] out_data1;
   logic [31:0] out_data2;
   logic [4:0]  out_rd;
   logic        out_we;
   logic        out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, flush, wb_en, wb_rd, wb_data, out_ready,
      input  in_ready, out_valid, out_op, out_data1, out_data2, out_rd, out_we, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, wb_en, wb_rd, wb_data, out_ready,
      output in_ready, out_valid, out_op, out_data1, out_data2, out_rd, out_we, out_illegal
   );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: register file, OP/OP-IMM/LUI/AUIPC decode, single-entry ID/EX buffer.
// Optional macro ID_STAGE_WB_BYPASS_EN enables write-through of the writeback port onto reads.
module id_stage #(
   parameter logic [31:0] RESET_PC_UNUSED = 32'd0
) (
   input logic       clk,
   input logic       rst,
   id_stage_if.slave bus
);
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   localparam logic [7:0] ALU_NOP  = 8'h00;
   localparam logic [7:0] ALU_ADD  = 8'h01;
   localparam logic [7:0] ALU_SUB  = 8'h02;
   localparam logic [7:0] ALU_SLL  = 8'h03;
   localparam logic [7:0] ALU_SLT  = 8'h04;
   localparam logic [7:0] ALU_SLTU = 8'h05;
   localparam logic [7:0] ALU_XOR  = 8'h06;
   localparam logic [7:0] ALU_SRL  = 8'h07;
   localparam logic [7:0] ALU_SRA  = 8'h08;
   localparam logic [7:0] ALU_OR   = 8'h09;
   localparam logic [7:0] ALU_AND  = 8'h0a;

   if (RESET_PC_UNUSED != 32'd0) begin : g_param_check
      $error("id_stage: RESET_PC_UNUSED must be 0");
   end

   // Instruction fields
   logic [6:0]  opcode;
   logic [4:0]  rd_idx;
   logic [2:0]  funct3;
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_u;

   assign opcode  = bus.in_instr[6:0];
   assign rd_idx  = bus.in_instr[11:7];
   assign funct3  = bus.in_instr[14:12];
   assign rs1_idx = bus.in_instr[19:15];
   assign rs2_idx = bus.in_instr[24:20];
   assign funct7  = bus.in_instr[31:25];
   assign imm_i   = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
   assign imm_u   = {bus.in_instr[31:12], 12'b0};

   // Register file; entry 0 is reset to zero and never written, so it always reads 0.
   logic [31:0] rf_reg [32];
   logic        wr_en;

   assign wr_en = bus.wb_en && (bus.wb_rd != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            rf_reg[i] <= '0;
         end
      end else if (wr_en) begin
         rf_reg[bus.wb_rd] <= bus.wb_data;
      end
   end

   logic [31:0] rs1_val;
   logic [31:0] rs2_val;

`ifdef ID_STAGE_WB_BYPASS_EN
   always_comb begin
      rs1_val = rf_reg[rs1_idx];
      rs2_val = rf_reg[rs2_idx];
      if (wr_en && (bus.wb_rd == rs1_idx)) rs1_val = bus.wb_data;
      if (wr_en && (bus.wb_rd == rs2_idx)) rs2_val = bus.wb_data;
   end
`else
   // Without bypass the read sees the pre-write value; hazard logic upstream stalls.
   always_comb begin
      rs1_val = rf_reg[rs1_idx];
      rs2_val = rf_reg[rs2_idx];
   end
`endif

   // Decoder
   logic [7:0]  dec_op;
   logic [31:0] dec_data1;
   logic [31:0] dec_data2;
   logic        dec_legal;

   always_comb begin
      dec_op    = ALU_NOP;
      dec_data1 = '0;
      dec_data2 = '0;
      dec_legal = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_data1 = rs1_val;
            dec_data2 = rs2_val;
            if (funct7 == F7_BASE) begin
               dec_legal = 1'b1;
               case (funct3)
                  3'b000:  dec_op = ALU_ADD;
                  3'b001:  dec_op = ALU_SLL;
                  3'b010:  dec_op = ALU_SLT;
                  3'b011:  dec_op = ALU_SLTU;
                  3'b100:  dec_op = ALU_XOR;
                  3'b101:  dec_op = ALU_SRL;
                  3'b110:  dec_op = ALU_OR;
                  default: dec_op = ALU_AND;
               endcase
               if (funct3 == 3'b001 || funct3 == 3'b101) begin
                  dec_data2 = {27'b0, rs2_val[4:0]};
               end
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               dec_legal = 1'b1;
               dec_op    = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               dec_legal = 1'b1;
               dec_op    = ALU_SRA;
               dec_data2 = {27'b0, rs2_val[4:0]};
            end
         end
         OPC_OPIMM: begin
            dec_data1 = rs1_val;
            dec_data2 = imm_i;
            dec_legal = 1'b1;
            case (funct3)
               3'b000: dec_op = ALU_ADD;
               3'b010: dec_op = ALU_SLT;
               3'b011: dec_op = ALU_SLTU;
               3'b100: dec_op = ALU_XOR;
               3'b110: dec_op = ALU_OR;
               3'b111: dec_op = ALU_AND;
               3'b001: begin
                  dec_op    = ALU_SLL;
                  dec_data2 = {27'b0, rs2_idx};
                  dec_legal = (funct7 == F7_BASE);
               end
               default: begin
                  dec_data2 = {27'b0, rs2_idx};
                  if (funct7 == F7_BASE) begin
                     dec_op = ALU_SRL;
                  end else if (funct7 == F7_ALT) begin
                     dec_op = ALU_SRA;
                  end else begin
                     dec_legal = 1'b0;
                  end
               end
            endcase
         end
         OPC_LUI: begin
            dec_op    = ALU_ADD;
            dec_data2 = imm_u;
            dec_legal = 1'b1;
         end
         OPC_AUIPC: begin
            dec_op    = ALU_ADD;
            dec_data1 = bus.in_pc;
            dec_data2 = imm_u;
            dec_legal = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // ID/EX output buffer
   logic        valid_reg, valid_next;
   logic [7:0]  op_reg, op_next;
   logic [31:0] data1_reg, data1_next;
   logic [31:0] data2_reg, data2_next;
   logic [4:0]  rd_reg, rd_next;
   logic        we_reg, we_next;
   logic        illegal_reg, illegal_next;
   logic        accept;

   assign bus.in_ready = !valid_reg || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

   always_comb begin
      valid_next   = valid_reg;
      op_next      = op_reg;
      data1_next   = data1_reg;
      data2_next   = data2_reg;
      rd_next      = rd_reg;
      we_next      = we_reg;
      illegal_next = illegal_reg;
      if (bus.flush) begin
         valid_next = 1'b0;
      end else if (accept) begin
         // Illegal encodings still travel as a bundle, but with every payload field zeroed.
         valid_next   = 1'b1;
         op_next      = dec_legal ? dec_op    : ALU_NOP;
         data1_next   = dec_legal ? dec_data1 : 32'd0;
         data2_next   = dec_legal ? dec_data2 : 32'd0;
         rd_next      = dec_legal ? rd_idx    : 5'd0;
         we_next      = dec_legal;
         illegal_next = !dec_legal;
      end else if (bus.out_ready) begin
         valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg   <= 1'b0;
         op_reg      <= '0;
         data1_reg   <= '0;
         data2_reg   <= '0;
         rd_reg      <= '0;
         we_reg      <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         valid_reg   <= valid_next;
         op_reg      <= op_next;
         data1_reg   <= data1_next;
         data2_reg   <= data2_next;
         rd_reg      <= rd_next;
         we_reg      <= we_next;
         illegal_reg <= illegal_next;
      end
   end

   assign bus.out_valid   = valid_reg;
   assign bus.out_op      = op_reg;
   assign bus.out_data1   = data1_reg;
   assign bus.out_data2   = data2_reg;
   assign bus.out_rd      = rd_reg;
   assign bus.out_we      = we_reg;
   assign bus.out_illegal = illegal_reg;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected bundles are queued at accept and checked at output handshake.
module tb_id_stage;
   logic clk;
   logic rst;

   id_stage_if bus ();

   id_stage #(.RESET_PC_UNUSED(32'd0)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [7:0]  op;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

`ifdef ID_STAGE_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   int   compared   = 0;
   int   mismatched = 0;
   exp_t sb[$];
   exp_t mon_exp;
   exp_t mon_got;

   function automatic exp_t mk(input logic [7:0] op, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [4:0] rd, input logic we, input logic ill);
      exp_t e;
      e.op = op; e.d1 = d1; e.d2 = d2; e.rd = rd; e.we = we; e.ill = ill;
      return e;
   endfunction

   function automatic exp_t got_now();
      return mk(bus.out_op, bus.out_data1, bus.out_data2, bus.out_rd, bus.out_we, bus.out_illegal);
   endfunction

   // addi rd, rs, 0: reads a register back through operand 1
   function automatic logic [31:0] rd_instr(input logic [4:0] rs, input logic [4:0] rd);
      return {12'd0, rs, 3'b000, rd, 7'b0010011};
   endfunction

   // Output monitor: every completed output handshake must match the oldest expected bundle.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         compared++;
         mon_got = got_now();
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL sb_unexpected got op=%h d1=%h d2=%h rd=%0d we=%b ill=%b, required none",
                     mon_got.op, mon_got.d1, mon_got.d2, mon_got.rd, mon_got.we, mon_got.ill);
         end else begin
            mon_exp = sb.pop_front();
            if (mon_got !== mon_exp) begin
               mismatched++;
               $display("FAIL sb_bundle got op=%h d1=%h d2=%h rd=%0d we=%b ill=%b, required op=%h d1=%h d2=%h rd=%0d we=%b ill=%b",
                        mon_got.op, mon_got.d1, mon_got.d2, mon_got.rd, mon_got.we, mon_got.ill,
                        mon_exp.op, mon_exp.d1, mon_exp.d2, mon_exp.rd, mon_exp.we, mon_exp.ill);
            end else begin
               $display("out  op=%h d1=%h d2=%h rd=%0d we=%b ill=%b ok",
                        mon_got.op, mon_got.d1, mon_got.d2, mon_got.rd, mon_got.we, mon_got.ill);
            end
         end
      end
   end

   // Called at posedge+1; presents one instruction until accepted, returns at posedge+1 after accept.
   task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e, input bit push);
      bit done;
      done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = pc;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            if (push) sb.push_back(e);
            $display("in   instr=%h pc=%h", instr, pc);
            done = 1'b1;
         end
      end
      if (!done) begin
         compared++;
         mismatched++;
         $display("FAIL send_timeout instr=%h in_ready=%b, required 1 within 50 cycles", instr, bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
      bus.wb_en   = 1'b1;
      bus.wb_rd   = rd;
      bus.wb_data = data;
      @(posedge clk);
      #1;
      bus.wb_en = 1'b0;
      $display("wb   x%0d=%h", rd, data);
   endtask

   task automatic test_reset();
      exp_t g;
      #12;
      compared++;
      g = got_now();
      if (bus.out_valid !== 1'b0 || g !== '0) begin
         mismatched++;
         $display("FAIL reset_state valid=%b bundle=%h, required valid=0 bundle=0", bus.out_valid, g);
      end
      compared++;
      if (bus.in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      wb_write(5'd1, 32'h0000_0005);
      wb_write(5'd2, 32'hFFFF_FFFD);
   endtask

   task automatic test_add();
      bus.out_ready = 1'b1;
      send(32'h002081B3, 32'h0, mk(8'h01, 32'd5, 32'hFFFF_FFFD, 5'd3, 1'b1, 1'b0), 1'b1);
      @(negedge clk);
      compared++;
      if (bus.out_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL add_latency out_valid got %b required 1 one cycle after accept", bus.out_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_decode();
      send(32'h4030D293, 32'h0, mk(8'h08, 32'd5, 32'd3, 5'd5, 1'b1, 1'b0), 1'b1);          // srai x5,x1,3
      send(32'h40209233, 32'h0, mk(8'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1), 1'b1);          // bad OP funct7
      send(32'h12345537, 32'h0, mk(8'h01, 32'd0, 32'h1234_5000, 5'd10, 1'b1, 1'b0), 1'b1); // lui
      send(32'h00001597, 32'h100, mk(8'h01, 32'h100, 32'h0000_1000, 5'd11, 1'b1, 1'b0), 1'b1); // auipc
      send(32'h40110633, 32'h0, mk(8'h02, 32'hFFFF_FFFD, 32'd5, 5'd12, 1'b1, 1'b0), 1'b1); // sub x12,x2,x1
      send(32'hFFF0B693, 32'h0, mk(8'h05, 32'd5, 32'hFFFF_FFFF, 5'd13, 1'b1, 1'b0), 1'b1); // sltiu x13,x1,-1
      send(32'h00209733, 32'h0, mk(8'h03, 32'd5, 32'h0000_001D, 5'd14, 1'b1, 1'b0), 1'b1); // sll x14,x1,x2
      send(32'h40309293, 32'h0, mk(8'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1), 1'b1);          // slli bad funct7
      send(32'h0000007F, 32'h0, mk(8'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1), 1'b1);          // unknown opcode
      send(32'h00000013, 32'h0, mk(8'h01, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0), 1'b1);          // addi x0: rd=0 still we
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      exp_t ea;
      exp_t eb;
      logic [31:0] instr;
      ea = mk(8'h02, 32'hFFFF_FFFD, 32'd5, 5'd12, 1'b1, 1'b0);
      eb = mk(8'h05, 32'd5, 32'hFFFF_FFFF, 5'd13, 1'b1, 1'b0);
      bus.out_ready = 1'b0;
      send(32'h40110633, 32'h0, ea, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'hFFF0B693;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         compared++;
         if (bus.in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL hold_in_ready cycle %0d got %b required 0", c, bus.in_ready);
         end
         compared++;
         if (bus.out_valid !== 1'b1 || got_now() !== ea) begin
            mismatched++;
            $display("FAIL hold_stable cycle %0d valid=%b bundle=%h, required valid=1 bundle=%h",
                     c, bus.out_valid, got_now(), ea);
         end
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      sb.push_back(eb);
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         instr = {7'd0, 5'(i + 16), 5'd0, 3'b000, 5'(i + 1), 7'b0010011};
         bus.in_instr = instr;
         @(negedge clk);
         compared++;
         if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_flow item %0d in_ready=%b out_valid=%b, required 1/1", i, bus.in_ready, bus.out_valid);
         end
         sb.push_back(mk(8'h01, 32'd0, 32'(i + 16), 5'(i + 1), 1'b1, 1'b0));
         $display("in   instr=%h (stream %0d)", instr, i);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      send(32'h002081B3, 32'h0, '0, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h12345537;
      bus.flush    = 1'b1;
      bus.wb_en    = 1'b1;
      bus.wb_rd    = 5'd4;
      bus.wb_data  = 32'h0000_00A5;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.wb_en    = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         compared++;
         if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_valid cycle %0d got %b required 0", c, bus.out_valid);
         end
      end
      @(posedge clk);
      #1;
      send(rd_instr(5'd4, 5'd7), 32'h0, mk(8'h01, 32'h0000_00A5, 32'd0, 5'd7, 1'b1, 1'b0), 1'b1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_bypass();
      bus.wb_en   = 1'b1;
      bus.wb_rd   = 5'd1;
      bus.wb_data = 32'h0000_0077;
      send(32'h00108313, 32'h0,
           mk(8'h01, BYPASS ? 32'h0000_0077 : 32'h0000_0005, 32'd1, 5'd6, 1'b1, 1'b0), 1'b1);
      bus.wb_en = 1'b0;
      send(rd_instr(5'd1, 5'd8), 32'h0, mk(8'h01, 32'h0000_0077, 32'd0, 5'd8, 1'b1, 1'b0), 1'b1);
      wb_write(5'd0, 32'h0000_0055);
      send(rd_instr(5'd0, 5'd9), 32'h0, mk(8'h01, 32'd0, 32'd0, 5'd9, 1'b1, 1'b0), 1'b1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midstream();
      bus.out_ready = 1'b0;
      send(32'h002081B3, 32'h0, '0, 1'b0);
      bus.wb_en   = 1'b1;
      bus.wb_rd   = 5'd3;
      bus.wb_data = 32'h0000_DEAD;
      #2;
      rst = 1'b1;
      #1;
      compared++;
      if (bus.out_valid !== 1'b0 || bus.out_op !== 8'h00) begin
         mismatched++;
         $display("FAIL async_reset valid=%b op=%h, required valid=0 op=00", bus.out_valid, bus.out_op);
      end
      @(posedge clk);
      #1;
      bus.wb_en = 1'b0;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      send(rd_instr(5'd1, 5'd8), 32'h0, mk(8'h01, 32'd0, 32'd0, 5'd8, 1'b1, 1'b0), 1'b1);
      send(rd_instr(5'd3, 5'd9), 32'h0, mk(8'h01, 32'd0, 32'd0, 5'd9, 1'b1, 1'b0), 1'b1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.flush     = 1'b0;
      bus.wb_en     = 1'b0;
      bus.wb_rd     = '0;
      bus.wb_data   = '0;
      bus.out_ready = 1'b0;

      test_reset();
      test_add();
      test_decode();
      test_back_to_back();
      test_flush();
      test_bypass();
      test_reset_midstream();

      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL sb_drain pending=%0d required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
